// File: rtl/shift_reg_vdelay.sv
// Multi-lane delay line with run-time depth, per-stage valid, stall and flush.
// Output is a registered tap at stage cfg_shift-1; no input-to-output path.
module shift_reg_vdelay #(
    parameter  int DATA      = 32,
    parameter  int LANES     = 4,
    parameter  int MAX_SHIFT = 16,
    localparam int SEL_W     = $clog2(MAX_SHIFT + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic [SEL_W-1:0]       shift_sel,
    input  logic                   valid_in,
    input  logic [LANES*DATA-1:0]  data_in,
    output logic                   valid_out,
    output logic [LANES*DATA-1:0]  data_out,
    output logic                   busy
);

    localparam int W = LANES * DATA;

    logic [W-1:0]         stg_d [MAX_SHIFT];
    logic [MAX_SHIFT-1:0] stg_v;
    logic [SEL_W-1:0]     cfg_shift;
    logic [SEL_W-1:0]     fill_cnt;
    logic [SEL_W-1:0]     eff_sel;
    logic                 reconfig;
    logic                 reload;
    logic                 tap_v;

    always_comb begin
        eff_sel = shift_sel;
        if (shift_sel == '0)
            eff_sel = SEL_W'(1);
        else if (shift_sel > SEL_W'(MAX_SHIFT))
            eff_sel = SEL_W'(MAX_SHIFT);
    end

    assign reconfig = (eff_sel != cfg_shift);
    // A flush alone leaves eff_sel == cfg_shift, so eff_sel reloads both cases
    assign reload   = reconfig | flush;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_SHIFT; i++)
                stg_d[i] <= '0;
            stg_v     <= '0;
            cfg_shift <= SEL_W'(MAX_SHIFT);
            fill_cnt  <= '0;
        end else begin
            if (en) begin
                stg_d[0] <= data_in;
                for (int i = 1; i < MAX_SHIFT; i++)
                    stg_d[i] <= stg_d[i-1];
            end
            if (reload) begin
                stg_v <= '0;
            end else if (en) begin
                stg_v[0] <= valid_in;
                for (int i = 1; i < MAX_SHIFT; i++)
                    stg_v[i] <= stg_v[i-1];
            end
            cfg_shift <= eff_sel;
            if (reload)
                fill_cnt <= eff_sel;
            else if (en && fill_cnt != '0)
                fill_cnt <= fill_cnt - SEL_W'(1);
        end
    end

    always_comb begin
        data_out = '0;
        tap_v    = 1'b0;
        for (int i = 0; i < MAX_SHIFT; i++) begin
            if (cfg_shift == SEL_W'(i + 1)) begin
                data_out = stg_d[i];
                tap_v    = stg_v[i];
            end
        end
    end

    assign busy      = (fill_cnt != '0);
    assign valid_out = tap_v & ~busy;

endmodule

// File: tb/tb_shift_reg_vdelay.sv
// Scoreboard bench for shift_reg_vdelay: words queued with their due en-count,
// popped when due; busy predicted from en-edges since the last reload.
module tb_shift_reg_vdelay;

    localparam int DATA  = 32;
    localparam int LANES = 4;
    localparam int MAX   = 16;
    localparam int SW    = $clog2(MAX + 1);
    localparam int W     = DATA * LANES;

    logic          clk = 1'b0;
    logic          reset_n, en, flush, valid_in;
    logic [SW-1:0] shift_sel;
    logic [W-1:0]  data_in;
    logic          valid_out, busy;
    logic [W-1:0]  data_out;

    shift_reg_vdelay #(
        .DATA(DATA), .LANES(LANES), .MAX_SHIFT(MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
        .shift_sel(shift_sel), .valid_in(valid_in), .data_in(data_in),
        .valid_out(valid_out), .data_out(data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           due;
    } exp_t;

    exp_t  q[$];
    int    total = 0;
    int    bad   = 0;
    int    ecnt  = 0;
    int    rel_e = -100;
    int    cfg_m = MAX;
    string phase = "init";

    task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s:%s got=%h exp=%h", phase, tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pat(int s);
        logic [W-1:0] v;
        logic [15:0]  lo;
        v = '0;
        for (int k = 0; k < LANES; k++) begin
            lo = 16'(16'h1111 * k);
            v[k*DATA +: DATA] = {s[15:0], lo};
        end
        return v;
    endfunction

    task automatic step(bit rn, bit e, bit fl, int sel, bit vi, int s);
        int  eff;
        bit  rl;
        bit  vexp;
        reset_n   = rn;
        en        = e;
        flush     = fl;
        shift_sel = SW'(sel);
        valid_in  = vi;
        data_in   = pat(s);
        @(posedge clk);
        if (!rn) begin
            q.delete();
            cfg_m = MAX;
            rel_e = ecnt - MAX - 1;
        end else begin
            eff = (sel == 0) ? 1 : ((sel > MAX) ? MAX : sel);
            rl  = (eff != cfg_m) || fl;
            if (e && q.size() > 0 && q[0].due == ecnt)
                void'(q.pop_front());
            if (e)
                ecnt++;
            if (rl) begin
                q.delete();
                cfg_m = eff;
                rel_e = ecnt;
            end else if (e && vi) begin
                q.push_back('{d: pat(s), due: ecnt + cfg_m - 1});
            end
        end
        #1;
        vexp = (q.size() > 0) && (q[0].due == ecnt);
        chk("valid", W'(valid_out), W'(vexp));
        chk("busy", W'(busy), W'((ecnt - rel_e) < cfg_m));
        if (vexp)
            chk("data", data_out, q[0].d);
        if (!rn)
            chk("rst_data", data_out, '0);
    endtask

    task automatic idle(int n, int sel);
        for (int i = 0; i < n; i++)
            step(1, 1, 0, sel, 0, 0);
    endtask

    initial begin
        phase = "reset";
        step(0, 1, 0, 5, 1, 16'h55);
        step(0, 1, 0, 5, 1, 16'h56);

        phase = "fill5";
        for (int i = 0; i < 10; i++)
            step(1, 1, 0, 5, 1, 16'hA0 + i);
        idle(8, 5);

        phase = "stall3";
        step(1, 1, 0, 3, 0, 0);
        idle(3, 3);
        step(1, 1, 0, 3, 1, 1);
        step(1, 1, 0, 3, 1, 2);
        step(1, 0, 0, 3, 1, 16'h99);
        step(1, 0, 0, 3, 1, 16'h98);
        step(1, 1, 0, 3, 1, 3);
        step(1, 1, 0, 3, 1, 4);
        step(1, 0, 0, 3, 0, 0);
        idle(6, 3);

        phase = "flush4";
        step(1, 1, 0, 4, 0, 0);
        idle(4, 4);
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 4, 1, 16'h40 + i);
        step(1, 1, 1, 4, 1, 16'h4F);
        for (int i = 0; i < 6; i++)
            step(1, 1, 0, 4, 1, 16'h50 + i);
        idle(6, 4);

        phase = "recfg8";
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 4, 1, 16'h60 + i);
        step(1, 0, 0, 8, 1, 16'h6F);
        for (int i = 0; i < 12; i++)
            step(1, 1, 0, 8, 1, 16'h70 + i);
        idle(10, 8);

        phase = "sel0";
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 0, 1, 16'h80 + i);
        step(1, 1, 0, 0, 1, 16'h84);
        idle(3, 0);

        phase = "selmax";
        for (int i = 0; i < 20; i++)
            step(1, 1, 0, MAX + 3, 1, 16'h90 + i);
        idle(MAX + 2, MAX + 3);

        phase = "midreset";
        step(1, 1, 0, 7, 0, 0);
        for (int i = 0; i < 5; i++)
            step(1, 1, 0, 7, 1, 16'hB0 + i);
        step(0, 1, 0, MAX, 1, 16'hBF);
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, MAX, 1, 16'hC0 + i);
        idle(MAX + 2, MAX);

        phase = "random";
        begin
            int sel;
            sel = 6;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 39) == 0)
                    sel = $urandom_range(0, MAX + 4);
                step(1, ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 29) == 0), sel,
                     $urandom_range(0, 1), 16'h1000 + i);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
